// File: rtl/soc_pio_pkg.sv
// Shared constants for the PIO block: register map and edge-detect modes.
package soc_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/soc_pio_edge_sync.sv
// Input resynchroniser, one-cycle delayed copy and per-bit edge flags.
module soc_pio_edge_sync
  import soc_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_flags
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_prev;

  // Synchroniser chain followed by the previous-value register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      in_prev <= '0;
    end else begin
      sync_q[0] <= pio_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      in_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  // Edge flags selected by the configured detection mode.
  always_comb begin
    edge_flags = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_flags = in_sync & ~in_prev;
      EDGE_FALL: edge_flags = ~in_sync & in_prev;
      default:   edge_flags = in_sync ^ in_prev;
    endcase
  end

endmodule

// File: rtl/soc_pio_v2.sv
// Memory-mapped parallel I/O port with edge capture and level interrupt.
module soc_pio_v2
  import soc_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = '0,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);

  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_flags;
  logic [WIDTH-1:0] ec_clr;
  logic [WIDTH-1:0] ec_set;
  logic [2:0]       arm_cnt;
  logic             armed;
  logic             unused_writedata;

  assign wr_en = chipselect & ~write_n;
  assign wd    = writedata[WIDTH-1:0];
  // Bits above WIDTH carry no meaning for this port.
  assign unused_writedata = ^writedata;

  soc_pio_edge_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_edge_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .pio_in     (pio_in),
    .in_sync    (in_sync),
    .edge_flags (edge_flags)
  );

  // Data, direction and mask registers; outset/outclear modify data in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE[WIDTH-1:0];
      dir_q    <= '0;
      mask_q   <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:    data_out <= wd;
        ADDR_DIR:     dir_q    <= wd;
        ADDR_IRQMASK: mask_q   <= wd;
        ADDR_OUTSET:  data_out <= data_out | wd;
        ADDR_OUTCLR:  data_out <= data_out & ~wd;
        default:      ;
      endcase
    end
  end

  // Arm counter: stays disarmed until the synchroniser and in_prev hold real input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (arm_cnt != ARM_DONE) begin
      arm_cnt <= arm_cnt + 3'd1;
    end
  end

  assign armed = (arm_cnt == ARM_DONE);

  // Clear and set terms for edge capture; set is applied after clear so a new edge wins.
  always_comb begin
    ec_clr = '0;
    ec_set = '0;
    if (wr_en && (address == ADDR_EDGECAP)) begin
      ec_clr = wd;
    end
    if (armed) begin
      ec_set = edge_flags & ~dir_q;
    end
  end

  // Edge capture register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap_q <= '0;
    end else begin
      edgecap_q <= (edgecap_q & ~ec_clr) | ec_set;
    end
  end

  // Zero-wait-state read mux, independent of chipselect.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = (dir_q & data_out) | (~dir_q & in_sync);
      ADDR_DIR:     readdata[WIDTH-1:0] = dir_q;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:      readdata = '0;
    endcase
  end

  assign pio_out = data_out;
  assign pio_oe  = dir_q;
  assign irq     = |(edgecap_q & mask_q);

endmodule
